// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: registered grant, round-robin on contention, zero-bubble handover.
// Optional burst limit compiled in with DBUS_ARB_BURST_LIMIT_EN.
module dbus_arbiter #(
    parameter int BUS_WORD_ADDR_WIDTH = 16,
    parameter int BURST_MAX           = 16
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_M0_Req,
    input  logic                           i_M1_Req,
    output logic                           o_M0_Gnt,
    output logic                           o_M1_Gnt,
    input  logic [BUS_WORD_ADDR_WIDTH-1:0] i_M0_Addr,
    input  logic                           i_M0_WE,
    input  logic [3:0]                     i_M0_ByteEn,
    input  logic [31:0]                    i_M0_WD,
    output logic [31:0]                    o_M0_RD,
    input  logic [BUS_WORD_ADDR_WIDTH-1:0] i_M1_Addr,
    input  logic                           i_M1_WE,
    input  logic [3:0]                     i_M1_ByteEn,
    input  logic [31:0]                    i_M1_WD,
    output logic [31:0]                    o_M1_RD,
    output logic [BUS_WORD_ADDR_WIDTH-1:0] o_DBus_Addr,
    output logic                           o_DBus_WE,
    output logic [3:0]                     o_DBus_ByteEn,
    output logic [31:0]                    o_DBus_WD,
    input  logic [31:0]                    i_DBus_RD,
    output logic [1:0]                     o_Owner
);

    // state | meaning
    // IDLE  | no master owns the bus, slave side driven to 0
    // OWN0  | M0 (CPU) owns the bus
    // OWN1  | M1 (DMA/debug) owns the bus
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    if (BURST_MAX < 2 || BURST_MAX > 256) begin : g_bad_burst_max
        $error("dbus_arbiter: BURST_MAX must be within 2..256");
    end

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   burst_expired;

`ifdef DBUS_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    logic [7:0] burst_cnt_q, burst_cnt_d;

    assign burst_expired = (burst_cnt_q == BURST_LAST);

    // Counts granted cycles of the current owner; any grant change restarts it.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_d != state_q || state_d == IDLE) begin
            burst_cnt_d = 8'd0;
        end else if (!burst_expired) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            burst_cnt_q <= 8'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign burst_expired = 1'b0;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // last_q names the master that most recently gave up the bus.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_M0_Req && i_M1_Req) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (i_M0_Req) begin
                    state_d = OWN0;
                end else if (i_M1_Req) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!i_M0_Req || (burst_expired && i_M1_Req)) begin
                    last_d  = 1'b0;
                    state_d = i_M1_Req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!i_M1_Req || (burst_expired && i_M0_Req)) begin
                    last_d  = 1'b1;
                    state_d = i_M0_Req ? OWN0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write enable is qualified by the owner's request so a released master never writes.
    always_comb begin
        o_M0_Gnt      = 1'b0;
        o_M1_Gnt      = 1'b0;
        o_Owner       = 2'b00;
        o_DBus_Addr   = '0;
        o_DBus_WE     = 1'b0;
        o_DBus_ByteEn = 4'h0;
        o_DBus_WD     = 32'h0;
        case (state_q)
            OWN0: begin
                o_M0_Gnt      = 1'b1;
                o_Owner       = 2'b01;
                o_DBus_Addr   = i_M0_Addr;
                o_DBus_WE     = i_M0_WE & i_M0_Req;
                o_DBus_ByteEn = i_M0_ByteEn;
                o_DBus_WD     = i_M0_WD;
            end
            OWN1: begin
                o_M1_Gnt      = 1'b1;
                o_Owner       = 2'b10;
                o_DBus_Addr   = i_M1_Addr;
                o_DBus_WE     = i_M1_WE & i_M1_Req;
                o_DBus_ByteEn = i_M1_ByteEn;
                o_DBus_WD     = i_M1_WD;
            end
            default: begin
            end
        endcase
    end

    assign o_M0_RD = i_DBus_RD;
    assign o_M1_RD = i_DBus_RD;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural ownership model.
module tb_dbus_arbiter;

    localparam int AW   = 16;
    localparam int BMAX = 4;
`ifdef DBUS_ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic          m0_gnt, m1_gnt;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]    m0_be = '0, m1_be = '0;
    logic [31:0]   m0_wd = '0, m1_wd = '0;
    logic [31:0]   m0_rd, m1_rd;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_wd;
    logic [31:0]   d_rd = '0;
    logic [1:0]    owner;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: owner is -1 (idle), 0 or 1; last is the master that last released.
    int m_owner = -1;
    int m_last  = 1;
    int m_run   = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.BUS_WORD_ADDR_WIDTH(AW), .BURST_MAX(BMAX)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_M0_Req(m0_req), .i_M1_Req(m1_req),
        .o_M0_Gnt(m0_gnt), .o_M1_Gnt(m1_gnt),
        .i_M0_Addr(m0_addr), .i_M0_WE(m0_we), .i_M0_ByteEn(m0_be), .i_M0_WD(m0_wd), .o_M0_RD(m0_rd),
        .i_M1_Addr(m1_addr), .i_M1_WE(m1_we), .i_M1_ByteEn(m1_be), .i_M1_WD(m1_wd), .o_M1_RD(m1_rd),
        .o_DBus_Addr(d_addr), .o_DBus_WE(d_we), .o_DBus_ByteEn(d_be), .o_DBus_WD(d_wd),
        .i_DBus_RD(d_rd), .o_Owner(owner)
    );

    function automatic void model_step(input logic r0, input logic r1);
        logic rx, ry;
        bit   preempt;
        if (m_owner < 0) begin
            if (r0 && r1)  m_owner = 1 - m_last;
            else if (r0)   m_owner = 0;
            else if (r1)   m_owner = 1;
            m_run = 0;
        end else begin
            rx = (m_owner == 0) ? r0 : r1;
            ry = (m_owner == 0) ? r1 : r0;
            preempt = BURST_EN && (m_run == BMAX - 1) && ry;
            if (rx && !preempt) begin
                if (m_run < BMAX - 1) m_run++;
            end else begin
                m_last  = m_owner;
                m_owner = ry ? 1 - m_owner : -1;
                m_run   = 0;
            end
        end
    endfunction

    task automatic tick();
        logic r0, r1;
        r0 = m0_req;
        r1 = m1_req;
        @(posedge clk);
        model_step(r0, r1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_owner = -1; m_last = 1; m_run = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        nchecks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || owner !== 2'b00) begin
            nerrors++;
            $display("FAIL reset_grants: gnt0=%b gnt1=%b owner=%b, required 0 0 00", m0_gnt, m1_gnt, owner);
        end
        nchecks++;
        if (d_addr !== '0 || d_we !== 1'b0 || d_be !== 4'h0 || d_wd !== 32'h0) begin
            nerrors++;
            $display("FAIL reset_dbus: addr=%h we=%b be=%h wd=%h, required all 0", d_addr, d_we, d_be, d_wd);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_be = 4'hF; m0_wd = 32'hDEADBEEF;
        #1;
        nchecks++;
        if (m0_gnt !== 1'b0 || d_we !== 1'b0) begin
            nerrors++;
            $display("FAIL grant_latency: gnt0=%b we=%b before edge, required 0 0", m0_gnt, d_we);
        end
        tick();
        nchecks++;
        if (m0_gnt !== 1'b1 || owner !== 2'b01) begin
            nerrors++;
            $display("FAIL m0_grant: gnt0=%b owner=%b, required 1 01", m0_gnt, owner);
        end
        nchecks++;
        if (d_addr !== 16'h0010 || d_we !== 1'b1 || d_be !== 4'hF || d_wd !== 32'hDEADBEEF) begin
            nerrors++;
            $display("FAIL m0_write: addr=%h we=%b be=%h wd=%h, required 0010 1 f deadbeef",
                     d_addr, d_we, d_be, d_wd);
        end
    endtask

    task automatic test_handover();
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        tick();
        nchecks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            nerrors++;
            $display("FAIL tie_first: gnt0=%b gnt1=%b, required 1 0", m0_gnt, m1_gnt);
        end
        m0_req = 1'b0;
        tick();
        d_rd = 32'h12345678;
        #1;
        nchecks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || owner !== 2'b10) begin
            nerrors++;
            $display("FAIL handover: gnt0=%b gnt1=%b owner=%b, required 0 1 10", m0_gnt, m1_gnt, owner);
        end
        nchecks++;
        if (m1_rd !== 32'h12345678 || m0_rd !== 32'h12345678) begin
            nerrors++;
            $display("FAIL read_bcast: rd0=%h rd1=%h, required 12345678", m0_rd, m1_rd);
        end
    endtask

    task automatic test_drop_we();
        m1_we = 1'b1; m1_addr = 16'h0ABC; m1_be = 4'h3; m1_wd = 32'hCAFEF00D;
        #1;
        nchecks++;
        if (d_we !== 1'b1 || d_addr !== 16'h0ABC) begin
            nerrors++;
            $display("FAIL m1_write: we=%b addr=%h, required 1 0abc", d_we, d_addr);
        end
        m1_req = 1'b0;
        #1;
        nchecks++;
        if (d_we !== 1'b0 || m1_gnt !== 1'b1) begin
            nerrors++;
            $display("FAIL drop_we: we=%b gnt1=%b, required 0 1", d_we, m1_gnt);
        end
        tick();
        nchecks++;
        if (owner !== 2'b00 || d_addr !== '0 || d_we !== 1'b0 || d_be !== 4'h0 || d_wd !== 32'h0) begin
            nerrors++;
            $display("FAIL drop_idle: owner=%b addr=%h we=%b be=%h wd=%h, required all 0",
                     owner, d_addr, d_we, d_be, d_wd);
        end
    endtask

    task automatic test_burst();
        int  n0;
        bit  seen1;
        do_reset();
        m0_req = 1'b1;
        tick();
        m1_req = 1'b1;
        n0 = 0;
        seen1 = 1'b0;
        for (int i = 0; i < 40 && !seen1; i++) begin
            if (m1_gnt === 1'b1) seen1 = 1'b1;
            else begin
                if (m0_gnt === 1'b1) n0++;
                tick();
            end
        end
        nchecks++;
        if (BURST_EN) begin
            if (!seen1 || n0 != BMAX) begin
                nerrors++;
                $display("FAIL burst_limit: m0 cycles=%0d m1 granted=%0d, required %0d 1", n0, seen1, BMAX);
            end
        end else begin
            if (seen1 || n0 != 40) begin
                nerrors++;
                $display("FAIL no_burst_limit: m0 cycles=%0d m1 granted=%0d, required 40 0", n0, seen1);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0042; m1_wd = 32'h0BADF00D;
        tick();
        nchecks++;
        if (m1_gnt !== 1'b1 || d_we !== 1'b1) begin
            nerrors++;
            $display("FAIL pre_reset_write: gnt1=%b we=%b, required 1 1", m1_gnt, d_we);
        end
        #2 rst = 1'b1;
        #1;
        nchecks++;
        if (m1_gnt !== 1'b0 || d_we !== 1'b0 || owner !== 2'b00) begin
            nerrors++;
            $display("FAIL async_reset: gnt1=%b we=%b owner=%b, required 0 0 00", m1_gnt, d_we, owner);
        end
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_owner = -1; m_last = 1; m_run = 0;
        @(negedge clk);
        nchecks++;
        if (owner !== 2'b00 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            nerrors++;
            $display("FAIL post_reset_idle: owner=%b gnt0=%b gnt1=%b, required 00 0 0", owner, m0_gnt, m1_gnt);
        end
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        nchecks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            nerrors++;
            $display("FAIL post_reset_tie: gnt0=%b gnt1=%b, required 1 0", m0_gnt, m1_gnt);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] ea;
        logic          ewe;
        logic [3:0]    ebe;
        logic [31:0]   ewd;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m0_req) m0_req = ($urandom_range(0, 5) != 0);
            else        m0_req = ($urandom_range(0, 2) == 0);
            if (m1_req) m1_req = ($urandom_range(0, 5) != 0);
            else        m1_req = ($urandom_range(0, 2) == 0);
            m0_addr = AW'($urandom); m1_addr = AW'($urandom);
            m0_we = 1'($urandom);    m1_we = 1'($urandom);
            m0_be = 4'($urandom);    m1_be = 4'($urandom);
            m0_wd = $urandom;        m1_wd = $urandom;
            d_rd  = $urandom;
            #1;
            ea = '0; ewe = 1'b0; ebe = 4'h0; ewd = 32'h0;
            if (m_owner == 0) begin
                ea = m0_addr; ewe = m0_we & m0_req; ebe = m0_be; ewd = m0_wd;
            end else if (m_owner == 1) begin
                ea = m1_addr; ewe = m1_we & m1_req; ebe = m1_be; ewd = m1_wd;
            end
            nchecks++;
            if (m0_gnt !== (m_owner == 0) || m1_gnt !== (m_owner == 1) ||
                owner !== ((m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00)) begin
                nerrors++;
                $display("FAIL rand_grant[%0d]: gnt0=%b gnt1=%b owner=%b, model owner=%0d",
                         i, m0_gnt, m1_gnt, owner, m_owner);
            end
            nchecks++;
            if (d_addr !== ea || d_we !== ewe || d_be !== ebe || d_wd !== ewd ||
                m0_rd !== d_rd || m1_rd !== d_rd) begin
                nerrors++;
                $display("FAIL rand_dbus[%0d]: addr=%h we=%b be=%h wd=%h, required %h %b %h %h",
                         i, d_addr, d_we, d_be, d_wd, ea, ewe, ebe, ewd);
            end
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_handover();
        test_drop_we();
        test_burst();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the CPU's simple word-addressed data bus. Master 0 is the CPU's data-bus port; master 1 is a secondary master such as a DMA engine or debug loader. The block sits between both masters and the shared slave side (RAM and peripherals). It grants the bus to one master at a time with a registered grant, using round-robin on contention and an optional burst limit.

## Interface
Parameters:
- BUS_WORD_ADDR_WIDTH, 16, word-address width, same as the CPU bus.
- BURST_MAX, 16, maximum consecutive granted cycles under contention (only used when the burst limit is compiled in). Legal range 2..256.

Ports:
- i_Clk  in  1  clock; everything changes on the rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_M0_Req, i_M1_Req  in  1 each  bus request, held high for as long as the master wants the bus.
- o_M0_Gnt, o_M1_Gnt  out  1 each  registered grant.
- i_Mx_Addr  in  BUS_WORD_ADDR_WIDTH  per-master word address (x = 0, 1).
- i_Mx_WE  in  1  per-master write enable.
- i_Mx_ByteEn  in  4  per-master byte enables.
- i_Mx_WD  in  32  per-master write data.
- o_Mx_RD  out  32  read data returned to each master.
- o_DBus_Addr  out  BUS_WORD_ADDR_WIDTH  slave-side address.
- o_DBus_WE  out  1  slave-side write enable.
- o_DBus_ByteEn  out  4  slave-side byte enables.
- o_DBus_WD  out  32  slave-side write data.
- i_DBus_RD  in  32  slave-side read data.
- o_Owner  out  2  current owner: 00 idle, 01 M0, 10 M1.

## Operation
- State machine has three states: IDLE, OWN0, OWN1. The grants and o_Owner decode directly from the state register.
- A last-owner bit (LAST) drives round-robin on contention.
- IDLE transitions:
  - only M0 requesting → OWN0.
  - only M1 requesting → OWN1.
  - both requesting → the master ≠ LAST.
  - neither requesting → stay in IDLE.
- OWNx while i_Mx_Req is high → stay in OWNx (subject to the burst limit).
- OWNx when i_Mx_Req drops → go to OWNy if y is requesting, else IDLE. The handover takes no idle cycle. LAST ← x.
- Slave-side mux is combinational from the state register:
  - Addr, ByteEn and WD come from the owner.
  - o_DBus_WE = owner's WE AND owner's Req, so a write is never issued by a master that has dropped its request.
- In IDLE, o_DBus_Addr, o_DBus_WE, o_DBus_ByteEn and o_DBus_WD are all 0.
- i_DBus_RD is broadcast to both o_M0_RD and o_M1_RD unchanged. A master uses RD only while it holds the grant.
- A master must not drive a transfer until it sees its grant. Requests issued without a grant have no effect on the slave side.

## Timing
- Reset values: state IDLE, LAST = 1 (M0 wins the first tie), both grants 0, o_Owner = 00, slave-side outputs 0, burst counter 0.
- Reset asserted mid-transfer clears the grants and o_DBus_WE immediately (asynchronously). A write in progress is abandoned.
- Grant latency: a request at edge N with the bus idle gives the grant high after edge N+1. The earliest transfer is in cycle N+1.
- Release: the owner drops Req during cycle N. Its grant falls after the next edge. The other master's grant rises on that same edge (zero bubble).
- Simultaneous first requests from reset: M0 is granted. At its release M1 is granted, because LAST = 0.
- A master that re-asserts Req in the same cycle its grant falls re-enters arbitration normally.

## Configuration
- Macro: DBUS_ARB_BURST_LIMIT_EN.
- Defined:
  - An 8-bit counter counts cycles the owner has held the grant. It resets to 0 on every grant change.
  - When the count reaches BURST_MAX−1 and the other master is requesting, the next edge moves the grant to the other master even though the current owner's Req is still high. LAST is updated.
  - The pre-empted master keeps Req high and regains the bus under normal round-robin.
  - With no competing request, the counter saturates and the owner keeps the bus.
- Undefined:
  - No counter exists.
  - Ownership lasts until the owner drops Req, so a master can starve the other indefinitely.

## Test plan
- Reset, then M0 requests at edge 2 → o_M0_Gnt = 1 after edge 3. Write to address 0x0010 with ByteEn = 0xF and WD = 0xDEADBEEF → these appear on the DBus with o_DBus_WE = 1. o_Owner = 01.
- Both masters request on the same edge out of reset → M0 is granted first. M0 drops Req → on the next edge o_M1_Gnt = 1 and o_M0_Gnt = 0, with no IDLE cycle. M1 reads 0x12345678 from i_DBus_RD on o_M1_RD.
- Owner holds its grant with WE = 1 but drops Req → o_DBus_WE = 0 in that cycle. State goes to IDLE on the next edge and the slave-side outputs are all 0.
- With DBUS_ARB_BURST_LIMIT_EN and BURST_MAX = 4, M0 holds Req continuously and M1 requests → M0 keeps exactly 4 granted cycles, then M1 is granted. With the macro undefined, M1 never gets the grant.
- Assert i_Rst between clock edges while M1 is writing → o_M1_Gnt and o_DBus_WE fall without waiting for an edge. After reset is released, the bus is idle with LAST = 1.
